bbg_burst_ctrl: RTL and testbench
=================================

Name: bbg_burst_ctrl

Overview:
- Burst scheduler for the baseband generator chain (PRBS/symbol source -> RC FIR -> polyphase interpolator -> IQ mixer).
- Sequences each burst through preamble, payload, filter flush and guard phases, all counted in symbol strobes.
- Gates symbol entry into the RC filter, selects the preamble pattern and re-seeds the PRBS at payload start.
- Produces a saturating amplitude ramp applied to the mixer output.

Parameters:
CNT_W, 16, width of phase-length inputs and phase counter
RAMP_STEP, 2048, gain increment/decrement per symbol strobe (Q1.15)
GAIN_MAX, 32767, gain saturation ceiling

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
sym_tick  in  1  one-cycle symbol strobe (data source cke)
start  in  1  start burst; honoured only in IDLE
abort  in  1  terminate burst early
cont  in  1  continuous mode: re-enter PRE after GUARD
pre_len  in  CNT_W  preamble length, symbols
pay_len  in  CNT_W  payload length, symbols
flush_len  in  CNT_W  filter drain length, symbols
guard_len  in  CNT_W  silent gap, symbols
den_gate  out  1  enables symbol entry into RC filters
pre_sel  out  1  1 = preamble pattern, 0 = PRBS
pn_rst  out  1  one-cycle PRBS re-seed pulse
tx_en  out  1  mixer output enable
gain  out  16  unsigned Q1.15 envelope gain
busy  out  1  state != IDLE
done  out  1  one-cycle end-of-burst pulse
burst_cnt  out  16  completed (non-aborted) bursts

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE, counter=0, gain=0, all 1-bit outputs 0, burst_cnt=0. Applies mid-burst with no drain.
- States: IDLE, PRE, PAY, FLUSH, GUARD. Phase order is fixed: PRE, PAY, FLUSH, GUARD.
- Length latch: pre/pay/flush/guard lengths are latched on the accepted start edge and again on each cont re-entry. Later input changes do not affect a running burst.
- Start: start=1 in IDLE at cycle t moves the state to the first nonzero-length phase at t+1, with busy=1 at t+1. Start is ignored outside IDLE.
- Phase counting:
  - On phase entry, counter = len-1.
  - Each sym_tick in the phase decrements the counter.
  - A sym_tick with counter==0 exits the phase on the next edge.
  - A phase therefore spans exactly len sym_ticks.
  - A sym_tick coincident with the entry edge is not counted.
- Zero-length phases are skipped. The next state is the first following phase with nonzero length. If none remains, the burst ends. All lengths zero: IDLE -> IDLE with done pulsed at t+1 and burst_cnt incremented.
- Burst end (exit of last phase):
  - If cont=1 and the burst was not aborted: re-latch lengths and enter the first nonzero phase; burst_cnt increments; done pulses.
  - Otherwise: go to IDLE, done pulses, and burst_cnt increments only if the burst was not aborted.
- Abort:
  - In PRE or PAY: next edge enters FLUSH (or GUARD/IDLE if those lengths are 0), sets the internal aborted flag, and forces no cont re-entry.
  - In FLUSH or GUARD: sets the flag only; the phase finishes normally.
  - In IDLE: ignored. abort and start in the same IDLE cycle: abort wins, stay IDLE.
- Decoded outputs (registered with state):
  - den_gate = PRE|PAY
  - pre_sel = PRE
  - tx_en = PRE|PAY|FLUSH
  - busy = state != IDLE
- pn_rst pulses for 1 cycle on the first cycle in PAY, including on cont re-entry.
- Gain, updated only on sym_tick:
  - In PRE/PAY: gain = min(gain+RAMP_STEP, GAIN_MAX).
  - In FLUSH/GUARD/IDLE: gain = max(gain-RAMP_STEP, 0).
  - Arithmetic uses 17 bits before saturation; no wrap.
- burst_cnt wraps 0xFFFF -> 0x0000.

Test Plan:
- Normal burst, sym_tick every 8 cycles; pre=4, pay=10, flush=5, guard=3; start pulse -> den_gate high 14 sym_ticks, pre_sel high for first 4, exactly one pn_rst, tx_en high 19 sym_ticks, done after 22nd, burst_cnt=1, busy=0 afterwards.
- Ramp, RAMP_STEP=2048 -> gain climbs 0, 2048, ... 30720, then saturates at 32767 by the 16th PRE/PAY tick; ramps down to 0 in FLUSH/GUARD/IDLE; never negative, never above 32767.
- Zero lengths: pre=0, pay=3, flush=0, guard=2 -> IDLE -> PAY directly (pn_rst pulses at t+1), then PAY -> GUARD. All four lengths zero -> done at t+1, busy never asserted.
- Abort at 5th payload tick (pay=10, flush=5, cont=1) -> FLUSH on next edge, den_gate drops, 5 flush + guard ticks, done pulses, no re-entry, burst_cnt unchanged. Same-cycle start+abort in IDLE -> no activity.
- Continuous mode cont=1, 3 bursts, with pre_len changed mid-burst -> change takes effect only at next re-entry, burst_cnt=3. Drop cont -> IDLE after current burst.
- rst=1 asserted in PAY with gain=20480 -> next edge: all outputs 0, burst_cnt=0. A start 1 cycle after rst release is accepted.

Source files
------------

// File: rtl/bbg_burst_ctrl.sv
// Burst scheduler for the baseband chain: sequences PRE/PAY/FLUSH/GUARD phases in
// symbol strobes, gates the RC filter input, re-seeds the PRBS and ramps the mixer gain.
module bbg_burst_ctrl #(
    parameter int CNT_W     = 16,
    parameter int RAMP_STEP = 2048,
    parameter int GAIN_MAX  = 32767
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sym_tick,
    input  logic             start,
    input  logic             abort,
    input  logic             cont,
    input  logic [CNT_W-1:0] pre_len,
    input  logic [CNT_W-1:0] pay_len,
    input  logic [CNT_W-1:0] flush_len,
    input  logic [CNT_W-1:0] guard_len,
    output logic             den_gate,
    output logic             pre_sel,
    output logic             pn_rst,
    output logic             tx_en,
    output logic [15:0]      gain,
    output logic             busy,
    output logic             done,
    output logic [15:0]      burst_cnt
);

    typedef enum logic [2:0] {IDLE, PRE, PAY, FLUSH, GUARD} state_t;

    localparam logic [16:0]      RAMP17 = 17'(RAMP_STEP);
    localparam logic [16:0]      GMAX17 = 17'(GAIN_MAX);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] pre_q, pre_d, pay_q, pay_d, flush_q, flush_d, guard_q, guard_d;
    logic             aborted_q, aborted_d;
    logic             pn_rst_q, pn_rst_d;
    logic             done_q, done_d;
    logic [15:0]      gain_q, gain_d;
    logic [15:0]      burst_cnt_q, burst_cnt_d;

    state_t           nxt, succ;
    logic             enter, finish, ab_now;
    logic [16:0]      sum17;

    // First phase at or after 'from' whose length is nonzero; IDLE if none remains.
    function automatic state_t first_nz(input state_t from, input logic [CNT_W-1:0] p,
                                        input logic [CNT_W-1:0] y, input logic [CNT_W-1:0] f,
                                        input logic [CNT_W-1:0] g);
        first_nz = IDLE;
        if (from == PRE && p != '0)                      first_nz = PRE;
        else if ((from == PRE || from == PAY) && y != '0) first_nz = PAY;
        else if (from != GUARD && f != '0)                first_nz = FLUSH;
        else if (g != '0)                                 first_nz = GUARD;
    endfunction

    function automatic logic [CNT_W-1:0] len_of(input state_t s, input logic [CNT_W-1:0] p,
                                                 input logic [CNT_W-1:0] y, input logic [CNT_W-1:0] f,
                                                 input logic [CNT_W-1:0] g);
        case (s)
            PRE:     len_of = p;
            PAY:     len_of = y;
            FLUSH:   len_of = f;
            GUARD:   len_of = g;
            default: len_of = '0;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pre_d       = pre_q;
        pay_d       = pay_q;
        flush_d     = flush_q;
        guard_d     = guard_q;
        aborted_d   = aborted_q;
        pn_rst_d    = 1'b0;
        done_d      = 1'b0;
        burst_cnt_d = burst_cnt_q;
        gain_d      = gain_q;
        nxt         = IDLE;
        succ        = IDLE;
        enter       = 1'b0;
        finish      = 1'b0;
        ab_now      = aborted_q;
        sum17       = {1'b0, gain_q} + RAMP17;

        if (sym_tick) begin
            if (state_q == PRE || state_q == PAY)
                gain_d = (sum17 > GMAX17) ? GMAX17[15:0] : sum17[15:0];
            else
                gain_d = ({1'b0, gain_q} < RAMP17) ? '0 : gain_q - RAMP17[15:0];
        end

        case (state_q)
            PRE:     succ = PAY;
            PAY:     succ = FLUSH;
            FLUSH:   succ = GUARD;
            default: succ = IDLE;
        endcase

        if (state_q == IDLE) begin
            if (start && !abort) begin
                pre_d     = pre_len;
                pay_d     = pay_len;
                flush_d   = flush_len;
                guard_d   = guard_len;
                aborted_d = 1'b0;
                nxt       = first_nz(PRE, pre_len, pay_len, flush_len, guard_len);
                enter     = (nxt != IDLE);
                finish    = (nxt == IDLE);
            end
        end else begin
            if (abort) ab_now = 1'b1;
            aborted_d = ab_now;
            if (abort && (state_q == PRE || state_q == PAY)) begin
                nxt    = first_nz(FLUSH, pre_q, pay_q, flush_q, guard_q);
                enter  = (nxt != IDLE);
                finish = (nxt == IDLE);
            end else if (sym_tick) begin
                if (cnt_q == '0) begin
                    if (succ != IDLE) nxt = first_nz(succ, pre_q, pay_q, flush_q, guard_q);
                    enter  = (nxt != IDLE);
                    finish = (nxt == IDLE);
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
        end

        // Burst end may immediately restart in continuous mode with freshly latched lengths.
        if (finish) begin
            done_d    = 1'b1;
            aborted_d = 1'b0;
            if (!ab_now) burst_cnt_d = burst_cnt_q + 16'd1;
            if (cont && !ab_now) begin
                pre_d   = pre_len;
                pay_d   = pay_len;
                flush_d = flush_len;
                guard_d = guard_len;
                nxt     = first_nz(PRE, pre_len, pay_len, flush_len, guard_len);
                enter   = (nxt != IDLE);
            end
            if (!enter) state_d = IDLE;
        end

        if (enter) begin
            state_d  = nxt;
            cnt_d    = len_of(nxt, pre_d, pay_d, flush_d, guard_d) - ONE;
            pn_rst_d = (nxt == PAY);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pre_q       <= '0;
            pay_q       <= '0;
            flush_q     <= '0;
            guard_q     <= '0;
            aborted_q   <= 1'b0;
            pn_rst_q    <= 1'b0;
            done_q      <= 1'b0;
            gain_q      <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pre_q       <= pre_d;
            pay_q       <= pay_d;
            flush_q     <= flush_d;
            guard_q     <= guard_d;
            aborted_q   <= aborted_d;
            pn_rst_q    <= pn_rst_d;
            done_q      <= done_d;
            gain_q      <= gain_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign den_gate  = (state_q == PRE) || (state_q == PAY);
    assign pre_sel   = (state_q == PRE);
    assign tx_en     = (state_q == PRE) || (state_q == PAY) || (state_q == FLUSH);
    assign busy      = (state_q != IDLE);
    assign pn_rst    = pn_rst_q;
    assign done      = done_q;
    assign gain      = gain_q;
    assign burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_bbg_burst_ctrl.sv
// Bench for bbg_burst_ctrl: randomized/directed scenarios checked every cycle against a
// phase-list reference model (phases 1..4 = PRE,PAY,FLUSH,GUARD, ticks remaining per phase).
module tb_bbg_burst_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0, sym_tick = 1'b0, start = 1'b0, abort = 1'b0, cont = 1'b0;
    logic [15:0] pre_len = '0, pay_len = '0, flush_len = '0, guard_len = '0;
    logic        den_gate, pre_sel, pn_rst, tx_en, busy, done;
    logic [15:0] gain, burst_cnt;

    bbg_burst_ctrl #(.CNT_W(16), .RAMP_STEP(2048), .GAIN_MAX(32767)) dut (
        .clk(clk), .rst(rst), .sym_tick(sym_tick), .start(start), .abort(abort), .cont(cont),
        .pre_len(pre_len), .pay_len(pay_len), .flush_len(flush_len), .guard_len(guard_len),
        .den_gate(den_gate), .pre_sel(pre_sel), .pn_rst(pn_rst), .tx_en(tx_en),
        .gain(gain), .busy(busy), .done(done), .burst_cnt(burst_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0, errors = 0, cyc = 0, period = 8;
    bit rand_tick = 1'b0;
    int n_den, n_pre, n_tx, n_busy, n_pn, n_done, max_gain;

    // Reference model state
    int m_len [1:4];
    int m_cur = 0, m_left = 0, m_gain = 0, m_cnt = 0;
    bit m_ab = 0, m_done = 0, m_pn = 0;

    function automatic int find_first(int k);
        for (int p = k; p <= 4; p++) if (m_len[p] != 0) return p;
        return 0;
    endfunction

    task automatic latch_lens();
        m_len[1] = pre_len; m_len[2] = pay_len; m_len[3] = flush_len; m_len[4] = guard_len;
    endtask

    task automatic end_burst();
        int p;
        m_done = 1;
        if (!m_ab) m_cnt = (m_cnt + 1) % 65536;
        m_cur = 0;
        if (cont && !m_ab) begin
            latch_lens();
            p = find_first(1);
            if (p != 0) begin m_cur = p; m_left = m_len[p]; m_pn = (p == 2); end
        end
        m_ab = 0;
    endtask

    task automatic go_from(int k);
        int p = find_first(k);
        if (p != 0) begin m_cur = p; m_left = m_len[p]; m_pn = (p == 2); end
        else end_burst();
    endtask

    task automatic model_step();
        m_done = 0; m_pn = 0;
        if (rst) begin
            m_cur = 0; m_left = 0; m_gain = 0; m_cnt = 0; m_ab = 0;
            return;
        end
        if (sym_tick) begin
            if (m_cur == 1 || m_cur == 2) m_gain = (m_gain + 2048 > 32767) ? 32767 : m_gain + 2048;
            else                          m_gain = (m_gain < 2048) ? 0 : m_gain - 2048;
        end
        if (m_cur == 0) begin
            if (start && !abort) begin latch_lens(); m_ab = 0; go_from(1); end
        end else if (abort && (m_cur == 1 || m_cur == 2)) begin
            m_ab = 1; go_from(3);
        end else begin
            if (abort) m_ab = 1;
            if (sym_tick) begin
                m_left--;
                if (m_left == 0) go_from(m_cur + 1);
            end
        end
    endtask

    function automatic bit gen_tick();
        return rand_tick ? ($urandom_range(0, 3) == 0) : (cyc % period == 0);
    endfunction

    // One clock: accumulate observed statistics, advance model, compare every output.
    task automatic step();
        if (sym_tick && den_gate) n_den++;
        if (sym_tick && pre_sel)  n_pre++;
        if (sym_tick && tx_en)    n_tx++;
        if (sym_tick && busy)     n_busy++;
        model_step();
        @(posedge clk); #1;
        cyc++;
        if (pn_rst === 1'b1) n_pn++;
        if (done === 1'b1)   n_done++;
        if (int'(gain) > max_gain) max_gain = int'(gain);
        vectors++;
        if (den_gate !== (m_cur == 1 || m_cur == 2)) begin errors++; $display("FAIL cyc%0d den_gate: got %b exp %b", cyc, den_gate, (m_cur == 1 || m_cur == 2)); end
        if (pre_sel !== (m_cur == 1)) begin errors++; $display("FAIL cyc%0d pre_sel: got %b exp %b", cyc, pre_sel, (m_cur == 1)); end
        if (tx_en !== (m_cur >= 1 && m_cur <= 3)) begin errors++; $display("FAIL cyc%0d tx_en: got %b exp %b", cyc, tx_en, (m_cur >= 1 && m_cur <= 3)); end
        if (busy !== (m_cur != 0)) begin errors++; $display("FAIL cyc%0d busy: got %b exp %b", cyc, busy, (m_cur != 0)); end
        if (pn_rst !== m_pn) begin errors++; $display("FAIL cyc%0d pn_rst: got %b exp %b", cyc, pn_rst, m_pn); end
        if (done !== m_done) begin errors++; $display("FAIL cyc%0d done: got %b exp %b", cyc, done, m_done); end
        if (gain !== 16'(m_gain)) begin errors++; $display("FAIL cyc%0d gain: got %0d exp %0d", cyc, gain, m_gain); end
        if (burst_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL cyc%0d burst_cnt: got %0d exp %0d", cyc, burst_cnt, m_cnt); end
    endtask

    task automatic drive(bit s, bit a);
        sym_tick = gen_tick(); start = s; abort = a;
        step();
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic clear_stats();
        n_den = 0; n_pre = 0; n_tx = 0; n_busy = 0; n_pn = 0; n_done = 0; max_gain = 0;
    endtask

    task automatic set_lens(int p, int y, int f, int g);
        pre_len = 16'(p); pay_len = 16'(y); flush_len = 16'(f); guard_len = 16'(g);
    endtask

    task automatic do_reset();
        rst = 1'b1; drive(0, 0); drive(0, 0); rst = 1'b0;
        clear_stats();
    endtask

    task automatic run_idle(int limit, string tag);
        int n = 0;
        while ((m_cur != 0 || busy !== 1'b0) && n < limit) begin drive(0, 0); n++; end
        if (m_cur != 0 || busy !== 1'b0) begin errors++; $display("FAIL %s timeout: busy=%b after %0d cycles", tag, busy, n); end
    endtask

    task automatic test_reset();
        rst = 1'b1; sym_tick = 1'b0; step(); step(); rst = 1'b0;
        vectors++;
        if ({den_gate, pre_sel, pn_rst, tx_en, busy, done, gain, burst_cnt} !== '0) begin
            errors++; $display("FAIL reset_state: got den=%b pre=%b pn=%b tx=%b busy=%b done=%b gain=%0d cnt=%0d exp all 0",
                               den_gate, pre_sel, pn_rst, tx_en, busy, done, gain, burst_cnt);
        end
    endtask

    task automatic test_normal();
        do_reset(); rand_tick = 0; period = 8; cont = 0;
        set_lens(4, 10, 5, 3);
        drive(1, 0);
        set_lens($urandom_range(1, 9), $urandom_range(1, 9), 0, 0);
        run_idle(400, "normal");
        drive(0, 0);
        vectors++; if (n_den != 14)  begin errors++; $display("FAIL normal_den_ticks: got %0d exp 14", n_den); end
        vectors++; if (n_pre != 4)   begin errors++; $display("FAIL normal_pre_ticks: got %0d exp 4", n_pre); end
        vectors++; if (n_tx != 19)   begin errors++; $display("FAIL normal_tx_ticks: got %0d exp 19", n_tx); end
        vectors++; if (n_busy != 22) begin errors++; $display("FAIL normal_busy_ticks: got %0d exp 22", n_busy); end
        vectors++; if (n_pn != 1)    begin errors++; $display("FAIL normal_pn_pulses: got %0d exp 1", n_pn); end
        vectors++; if (n_done != 1)  begin errors++; $display("FAIL normal_done_pulses: got %0d exp 1", n_done); end
        vectors++; if (burst_cnt !== 16'd1 || busy !== 1'b0) begin errors++; $display("FAIL normal_end: got cnt=%0d busy=%b exp cnt=1 busy=0", burst_cnt, busy); end
    endtask

    task automatic test_ramp();
        do_reset(); rand_tick = 0; period = 3; cont = 0;
        set_lens(6, 14, 9, 9);
        drive(1, 0);
        run_idle(400, "ramp");
        for (int i = 0; i < 60; i++) drive(0, 0);
        vectors++; if (max_gain != 32767) begin errors++; $display("FAIL ramp_peak: got %0d exp 32767", max_gain); end
        vectors++; if (gain !== 16'd0)    begin errors++; $display("FAIL ramp_floor: got %0d exp 0", gain); end
    endtask

    task automatic test_zero_len();
        do_reset(); rand_tick = 0; period = 4; cont = 0;
        set_lens(0, 3, 0, 2);
        drive(1, 0);
        vectors++; if (pn_rst !== 1'b1 || pre_sel !== 1'b0 || den_gate !== 1'b1) begin
            errors++; $display("FAIL zero_direct_pay: got pn=%b pre=%b den=%b exp 1 0 1", pn_rst, pre_sel, den_gate);
        end
        run_idle(200, "zero_len");
        vectors++; if (n_tx != 3) begin errors++; $display("FAIL zero_tx_ticks: got %0d exp 3", n_tx); end
        set_lens(0, 0, 0, 0);
        clear_stats();
        drive(1, 0);
        vectors++; if (done !== 1'b1 || busy !== 1'b0 || burst_cnt !== 16'd2) begin
            errors++; $display("FAIL all_zero: got done=%b busy=%b cnt=%0d exp 1 0 2", done, busy, burst_cnt);
        end
        for (int i = 0; i < 5; i++) drive(0, 0);
        vectors++; if (n_done != 1) begin errors++; $display("FAIL all_zero_done_count: got %0d exp 1", n_done); end
    endtask

    task automatic test_abort();
        int n = 0;
        do_reset(); rand_tick = 0; period = 8; cont = 1;
        set_lens(4, 10, 5, 3);
        drive(1, 0);
        while (!(m_cur == 2 && m_left == 6 && gen_tick()) && n < 400) begin drive(0, 0); n++; end
        drive(0, 1);
        vectors++; if (den_gate !== 1'b0 || tx_en !== 1'b1) begin errors++; $display("FAIL abort_to_flush: got den=%b tx=%b exp 0 1", den_gate, tx_en); end
        clear_stats();
        run_idle(400, "abort");
        vectors++; if (n_busy != 8 || n_done != 1 || burst_cnt !== 16'd0) begin
            errors++; $display("FAIL abort_tail: got ticks=%0d done=%0d cnt=%0d exp 8 1 0", n_busy, n_done, burst_cnt);
        end
        cont = 0;
        drive(1, 1);
        for (int i = 0; i < 4; i++) drive(0, 0);
        vectors++; if (busy !== 1'b0 || burst_cnt !== 16'd0) begin errors++; $display("FAIL start_abort_idle: got busy=%b cnt=%0d exp 0 0", busy, burst_cnt); end
    endtask

    task automatic test_cont();
        int n = 0;
        do_reset(); rand_tick = 1; cont = 1;
        set_lens(2, 3, 1, 2);
        drive(1, 0);
        while (n_done < 1 && n < 600) begin
            if (n == 10) pre_len = 16'd5;
            drive(0, 0); n++;
        end
        while (n_done < 2 && n < 1200) begin drive(0, 0); n++; end
        cont = 0;
        run_idle(600, "cont");
        vectors++; if (burst_cnt !== 16'd3 || n_done != 3) begin errors++; $display("FAIL cont_bursts: got cnt=%0d done=%0d exp 3 3", burst_cnt, n_done); end
    endtask

    task automatic test_rst_mid();
        int n = 0;
        do_reset(); rand_tick = 0; period = 4; cont = 0;
        set_lens(4, 10, 5, 3);
        drive(1, 0);
        while (!(m_cur == 2 && m_gain == 20480) && n < 400) begin drive(0, 0); n++; end
        vectors++; if (gain !== 16'd20480) begin errors++; $display("FAIL rst_mid_setup: got gain=%0d exp 20480", gain); end
        rst = 1'b1; drive(0, 0); rst = 1'b0;
        vectors++; if ({den_gate, pre_sel, pn_rst, tx_en, busy, done, gain, burst_cnt} !== '0) begin
            errors++; $display("FAIL rst_mid: got busy=%b gain=%0d cnt=%0d exp all 0", busy, gain, burst_cnt);
        end
        drive(0, 0);
        drive(1, 0);
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL start_after_rst: got busy=%b exp 1", busy); end
        run_idle(400, "rst_mid");
    endtask

    task automatic test_random();
        do_reset(); rand_tick = 1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0)
                set_lens($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3));
            cont = ($urandom_range(0, 3) != 0);
            rst  = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0);
            rst = 1'b0;
        end
        cont = 0;
        run_idle(600, "random");
    endtask

    initial begin
        clear_stats();
        test_reset();
        test_normal();
        test_ramp();
        test_zero_len();
        test_abort();
        test_cont();
        test_rst_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
